// File: rtl/ex_trap_arbiter.sv
// ex_trap_arbiter: shares the core's single external-interrupt handshake among
// SRC_NUM interrupt sources. Each raw line is synchronised, rising-edge
// detected and latched as pending; a round-robin scheduler presents one
// request at a time to the core and reports which source was serviced.

module ex_trap_arbiter #(
  parameter  int SRC_NUM     = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(SRC_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] src_irq_i,
  input  logic [SRC_NUM-1:0] src_en_i,
  input  logic [SRC_NUM-1:0] pend_clr_i,
  output logic               core_ex_trap_valid_o,
  input  logic               core_ex_trap_ready_i,
  output logic [ID_W-1:0]    trap_id_o,
  output logic               trap_id_vld_o,
  output logic [SRC_NUM-1:0] pend_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][SRC_NUM-1:0] sync_q;
  logic [SRC_NUM-1:0]                  synced;
  logic [SRC_NUM-1:0]                  prev_q;
  logic [SRC_NUM-1:0]                  rise_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Shift the raw IRQ lines through the synchroniser chain.
  // NOTE: the chain is cleared on reset so that a line held high across reset
  // release is seen as a fresh 0->1 transition and produces exactly one rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_irq_i};
    end
  end

  // Remember the previous synced level and register the one-cycle rise pulse.
  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // with = the rise would compare synced against its own new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= synced;
      rise_q <= synced & ~prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending vector
  // ---------------------------------------------------------------------------
  logic [SRC_NUM-1:0] pend_q;
  logic [SRC_NUM-1:0] pend_d;
  logic [SRC_NUM-1:0] pend_set;
  logic [SRC_NUM-1:0] pend_clr;
  logic [SRC_NUM-1:0] accept_mask;
  logic [SRC_NUM-1:0] elig;

  state_e            state_q;
  state_e            state_d;
  logic              valid_q;
  logic              valid_d;
  logic [ID_W-1:0]   trap_id_q;
  logic [ID_W-1:0]   trap_id_d;
  logic              trap_id_vld_q;
  logic              trap_id_vld_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic              accept;

  assign accept      = (state_q == ST_REQ) && core_ex_trap_ready_i;
  assign accept_mask = accept ? (SRC_NUM'(1) << trap_id_q) : '0;
  assign pend_set    = rise_q & src_en_i;
  assign pend_clr    = pend_clr_i | accept_mask;
  assign elig        = pend_q & src_en_i;

  // Clear first, then set, so a rise in the same cycle as a clear wins.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  // Pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first eligible source at or after ptr_q, wrapping.
  // ---------------------------------------------------------------------------
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  int              idx;

  // Scan all sources starting from the pointer, keep the first hit.
  // NOTE: every variable gets a default before the loop; otherwise a path that
  // finds nothing would leave it unassigned and infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    idx        = 0;
    for (int i = 0; i < SRC_NUM; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= SRC_NUM) begin
        idx = idx - SRC_NUM;
      end
      if (!pick_found && elig[idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------

  // Next-state and registered-output logic for the request handshake.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    trap_id_d     = trap_id_q;
    trap_id_vld_d = 1'b0;
    ptr_d         = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        // ready is deliberately ignored here: only a raised valid can accept.
        if (pick_found) begin
          trap_id_d = pick_id;
          valid_d   = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // The request is never withdrawn once raised, even if its source is
        // cleared or masked meanwhile.
        if (core_ex_trap_ready_i) begin
          valid_d       = 1'b0;
          trap_id_vld_d = 1'b1;
          if (int'(trap_id_q) == SRC_NUM - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = trap_id_q + ID_W'(1);
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Wait for the core to drop ready before offering the next request.
        if (!core_ex_trap_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      valid_q       <= 1'b0;
      trap_id_q     <= '0;
      trap_id_vld_q <= 1'b0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      trap_id_q     <= trap_id_d;
      trap_id_vld_q <= trap_id_vld_d;
      ptr_q         <= ptr_d;
    end
  end

  assign core_ex_trap_valid_o = valid_q;
  assign trap_id_o            = trap_id_q;
  assign trap_id_vld_o        = trap_id_vld_q;
  assign pend_o               = pend_q;

endmodule

// File: tb/tb_ex_trap_arbiter.sv
// Directed bench for ex_trap_arbiter: a 4-source instance exercises latency,
// round-robin order, masking, request hold, DONE gating and mid-request reset;
// a 3-source instance checks pointer wrap on a non-power-of-two count.

module tb_ex_trap_arbiter;

  logic clk;

  // 4-source instance
  logic       rst4;
  logic [3:0] irq4, en4, clr4, pend4;
  logic       rdy4, valid4, vld4;
  logic [1:0] id4;

  // 3-source instance
  logic       rst3;
  logic [2:0] irq3, en3, clr3, pend3;
  logic       rdy3, valid3, vld3;
  logic [1:0] id3;

  int tests  = 0;
  int failed = 0;

  ex_trap_arbiter #(.SRC_NUM(4), .SYNC_STAGES(2)) dut4 (
    .clk                  (clk),
    .rst                  (rst4),
    .src_irq_i            (irq4),
    .src_en_i             (en4),
    .pend_clr_i           (clr4),
    .core_ex_trap_valid_o (valid4),
    .core_ex_trap_ready_i (rdy4),
    .trap_id_o            (id4),
    .trap_id_vld_o        (vld4),
    .pend_o               (pend4)
  );

  ex_trap_arbiter #(.SRC_NUM(3), .SYNC_STAGES(2)) dut3 (
    .clk                  (clk),
    .rst                  (rst3),
    .src_irq_i            (irq3),
    .src_en_i             (en3),
    .pend_clr_i           (clr3),
    .core_ex_trap_valid_o (valid3),
    .core_ex_trap_ready_i (rdy3),
    .trap_id_o            (id3),
    .trap_id_vld_o        (vld3),
    .pend_o               (pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset4();
    rst4 = 1'b1; irq4 = '0; clr4 = '0; rdy4 = 1'b0; en4 = 4'hF;
    tick(); tick();
    rst4 = 1'b0;
  endtask

  task automatic wait_valid4(input string tag);
    int n = 0;
    while (valid4 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(valid4), 32'd1);
  endtask

  // Wait for a request, hold ready low 3 cycles, accept for one cycle, drop.
  task automatic serve4(input int exp_id, input string tag);
    wait_valid4({tag, "_valid"});
    check({tag, "_id"}, 32'(id4), 32'(exp_id));
    rdy4 = 1'b0;
    repeat (3) tick();
    check({tag, "_hold"}, 32'(valid4), 32'd1);
    rdy4 = 1'b1;
    tick();
    check({tag, "_vld"}, 32'(vld4), 32'd1);
    check({tag, "_drop"}, 32'(valid4), 32'd0);
    check({tag, "_pclr"}, 32'(pend4[exp_id]), 32'd0);
    rdy4 = 1'b0;
    tick();
    check({tag, "_vld0"}, 32'(vld4), 32'd0);
  endtask

  task automatic serve3(input int exp_id, input string tag);
    int n = 0;
    while (valid3 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(valid3), 32'd1);
    check({tag, "_id"}, 32'(id3), 32'(exp_id));
    rdy3 = 1'b1;
    tick();
    check({tag, "_vld"}, 32'(vld3), 32'd1);
    rdy3 = 1'b0;
    tick();
  endtask

  initial begin
    rst3 = 1'b1; irq3 = '0; en3 = 3'h7; clr3 = '0; rdy3 = 1'b0;

    // ---------------- T1: single source, ready tied high ----------------
    reset4();
    rst4 = 1'b1;
    tick();
    check("t1_rst_valid", 32'(valid4), 32'd0);
    check("t1_rst_pend",  32'(pend4),  32'd0);
    check("t1_rst_vld",   32'(vld4),   32'd0);
    check("t1_rst_id",    32'(id4),    32'd0);
    rst4 = 1'b0;
    rdy4 = 1'b1;
    irq4 = 4'b0100;
    repeat (4) tick();
    check("t1_pend_lat",  32'(pend4),  32'h4);
    check("t1_no_valid",  32'(valid4), 32'd0);
    tick();
    check("t1_valid",     32'(valid4), 32'd1);
    check("t1_id",        32'(id4),    32'd2);
    tick();
    check("t1_acc_valid", 32'(valid4), 32'd0);
    check("t1_acc_vld",   32'(vld4),   32'd1);
    check("t1_acc_pend",  32'(pend4),  32'd0);
    check("t1_acc_id",    32'(id4),    32'd2);
    tick();
    check("t1_vld_pulse", 32'(vld4),   32'd0);
    check("t1_id_hold",   32'(id4),    32'd2);
    rdy4 = 1'b0;
    tick();

    // ---------------- T2: round robin ----------------
    reset4();
    irq4 = 4'hF;
    serve4(0, "t2_a0");
    serve4(1, "t2_a1");
    serve4(2, "t2_a2");
    serve4(3, "t2_a3");
    check("t2_pend_empty", 32'(pend4), 32'd0);
    irq4 = 4'h0;
    repeat (5) tick();
    irq4 = 4'b0011;
    serve4(0, "t2_b0");
    serve4(1, "t2_b1");

    // ---------------- T3: enable mask ----------------
    reset4();
    en4  = 4'b1110;
    irq4 = 4'b0001;
    repeat (8) tick();
    check("t3_masked_pend",  32'(pend4),  32'd0);
    check("t3_masked_valid", 32'(valid4), 32'd0);
    en4  = 4'hF;
    irq4 = 4'b0000;
    repeat (5) tick();
    check("t3_no_late_pend", 32'(pend4),  32'd0);
    irq4 = 4'b0001;
    serve4(0, "t3_src0");

    // ---------------- T4: request held through clear/mask ----------------
    reset4();
    irq4 = 4'b0010;
    wait_valid4("t4_valid");
    check("t4_id", 32'(id4), 32'd1);
    clr4 = 4'b0010;
    en4  = 4'b1101;
    tick();
    clr4 = 4'b0000;
    check("t4_pend_cleared", 32'(pend4),  32'd0);
    repeat (19) tick();
    check("t4_still_valid",  32'(valid4), 32'd1);
    check("t4_id_kept",      32'(id4),    32'd1);
    rdy4 = 1'b1;
    tick();
    check("t4_acc_vld",      32'(vld4),   32'd1);
    check("t4_acc_id",       32'(id4),    32'd1);
    check("t4_acc_valid",    32'(valid4), 32'd0);
    rdy4 = 1'b0;
    en4  = 4'hF;
    repeat (12) tick();
    check("t4_no_rereq",     32'(valid4), 32'd0);
    check("t4_pend_zero",    32'(pend4),  32'd0);

    // ---------------- T5: DONE gating ----------------
    reset4();
    irq4 = 4'b0011;
    wait_valid4("t5_valid");
    check("t5_id0", 32'(id4), 32'd0);
    rdy4 = 1'b1;
    tick();
    check("t5_acc_vld", 32'(vld4), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_gated", 32'(valid4), 32'd0);
    end
    check("t5_pend1", 32'(pend4), 32'h2);
    rdy4 = 1'b0;
    tick();
    check("t5_done_exit", 32'(valid4), 32'd0);
    tick();
    check("t5_next_valid", 32'(valid4), 32'd1);
    check("t5_next_id",    32'(id4),    32'd1);
    rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    tick();

    // ---------------- T6: reset during REQ ----------------
    reset4();
    irq4 = 4'b1000;
    wait_valid4("t6_valid");
    check("t6_id", 32'(id4), 32'd3);
    rst4 = 1'b1;
    tick();
    check("t6_rst_valid", 32'(valid4), 32'd0);
    check("t6_rst_pend",  32'(pend4),  32'd0);
    check("t6_rst_id",    32'(id4),    32'd0);
    check("t6_rst_vld",   32'(vld4),   32'd0);
    rst4 = 1'b0;
    serve4(3, "t6_redetect");
    repeat (15) tick();
    check("t6_once_valid", 32'(valid4), 32'd0);
    check("t6_once_pend",  32'(pend4),  32'd0);

    // ---------------- SRC_NUM=3 pointer wrap ----------------
    rst3 = 1'b1;
    tick(); tick();
    check("n3_rst_valid", 32'(valid3), 32'd0);
    check("n3_rst_pend",  32'(pend3),  32'd0);
    rst3 = 1'b0;
    irq3 = 3'b100;
    serve3(2, "n3_src2");
    check("n3_id_hold", 32'(id3), 32'd2);
    irq3 = 3'b000;
    repeat (5) tick();
    irq3 = 3'b011;
    serve3(0, "n3_wrap0");
    serve3(1, "n3_wrap1");
    check("n3_pend_empty", 32'(pend3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
